playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
- Downstream consumer of the 3-entry LIFO duration store.
- On `start`, pops stored 12-bit durations one at a time via `mem_read`/`mem_data`.
- For each entry, drives `play_out` high for duration×TICK_DIV cycles, then low for a fixed gap.
- Stops on a zero entry, after MAX_ENTRIES entries, or on `abort`. Feeds the LED/tone output stage.

Parameters:
- DATA_W, 12: width of `mem_data` and of the duration counter.
- TICK_DIV, 1000: clk cycles per duration tick (≥1).
- GAP_TICKS, 4: low ticks between entries (0 allowed = no gap).
- MAX_ENTRIES, 3: hard cap on entries per playback (the store returns slot 0 repeatedly once empty).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  1-cycle request to begin playback; ignored while busy.
- abort  in  1  stop immediately; wins over start.
- mem_data  in  DATA_W  current top-of-store value (combinational from store).
- mem_read  out  1  1-cycle pop strobe to store.
- play_out  out  1  registered playback output.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse on normal completion.
- entries_played  out  $clog2(MAX_ENTRIES+1)  entries played this run.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; play_out=0, mem_read=0, busy=0, done=0, entries_played=0; counters=0. Reset mid-playback aborts without done and without mem_read.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 & abort=0 → LOAD; entries_played cleared the same edge.
- LOAD (1 cycle), evaluated in order:
  - If entries_played==MAX_ENTRIES or mem_data==0 → DONE, no pop.
  - Otherwise: mem_read=1 this cycle only; dur←mem_data; prescaler←0; entries_played+1; → PLAY.
- PLAY: play_out=1. Prescaler counts 0..TICK_DIV-1; at wrap dur decrements. When dur==1 and the prescaler wraps → GAP (or → LOAD if GAP_TICKS==0). Result: exactly mem_data×TICK_DIV high cycles.
- GAP: play_out=0 for exactly GAP_TICKS×TICK_DIV cycles, then → LOAD.
- DONE: done=1 for one cycle; → IDLE. busy is high in DONE, low next cycle.
- Latency: start sampled at edge N → LOAD during cycle N+1 (mem_read during N+1) → play_out high from edge N+2.
- The store pops at the edge ending LOAD; the next LOAD sees the new top. mem_data is sampled only in LOAD.
- abort=1 at any edge: → IDLE; play_out=0, mem_read=0, no done pulse. entries_played holds its value until the next start.
- start while busy: ignored, no restart.
- Counter widths:
  - dur is DATA_W bits, loaded value ≥1 (0 never loaded), no underflow.
  - Prescaler width is $clog2(TICK_DIV) bits, min 1.
  - Gap counter width fits GAP_TICKS.
- All outputs are registered except mem_read, which is decoded from state==LOAD & accept.

Decomposition:
- Shared package `absentees_pkg`:
  - state enum `play_state_t` (IDLE, LOAD, PLAY, GAP, DONE).
  - constant `DUR_W=12` shared with the store's count width.
- One natural sub-module: `tick_prescaler`, a TICK_DIV-cycle divider with sync clear and a 1-cycle `tick` output. It is reused by both PLAY and GAP.
- Everything else is single-module FSM plus counters.

Test Plan:
- All scenarios use TICK_DIV=2, GAP_TICKS=1, MAX_ENTRIES=3.
- Reset: hold rst 3 cycles mid-PLAY → next cycle all outputs 0, state IDLE, no done.
- Single entry: store holds 5 then 0; pulse start at edge N:
  - mem_read in cycle N+1; play_out high cycles N+2..N+11 (10 cycles), low 2 gap cycles.
  - LOAD sees 0; done pulses once; entries_played=1.
- Three entries 3,1,2 then MAX cap (store keeps returning 2):
  - high widths 6,2,4 separated by 2-cycle gaps.
  - exactly 3 mem_read pulses; done after third gap; entries_played=3.
- Empty store (mem_data=0 at start): done pulses in cycle N+2, play_out never high, zero mem_read.
- Abort during the second entry's PLAY: play_out=0 next cycle, busy=0, no done, entries_played=2 holds. Start+abort in the same cycle → stays IDLE.
- Start reissued while busy (mid-GAP): ignored, sequence timing unchanged. Max duration 4095 with TICK_DIV=1: high exactly 4095 cycles, no wrap.

Source files
------------

// File: rtl/absentees_pkg.sv
// Shared definitions for the playback sequencer and the duration store.
//   play_state_t : sequencer FSM state encoding
//   DUR_W        : duration width, shared with the store's count width
//   cnt_width()  : width of a counter that counts 0..n-1 (minimum 1 bit)
package absentees_pkg;

    localparam int unsigned DUR_W = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } play_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// Handshake/bus bundle between a playback controller, the duration store
// and the playback sequencer.
//   start, abort     : controller requests (1-cycle start, level abort)
//   mem_data         : current top-of-store duration (combinational)
//   mem_read         : 1-cycle pop strobe back to the store
//   play_out         : registered playback output
//   busy, done       : status (done is a 1-cycle completion pulse)
//   entries_played   : entries played in the current/last run
// Modports: slave = sequencer side, master = controller/store side.
interface playback_sequencer_if #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned MAX_ENTRIES = 3
);
    localparam int unsigned EW = $clog2(MAX_ENTRIES + 1);

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] mem_data;
    logic              mem_read;
    logic              play_out;
    logic              busy;
    logic              done;
    logic [EW-1:0]     entries_played;

    modport slave (
        input  start, abort, mem_data,
        output mem_read, play_out, busy, done, entries_played
    );

    modport master (
        output start, abort, mem_data,
        input  mem_read, play_out, busy, done, entries_played
    );

endinterface

// File: rtl/tick_prescaler.sv
// TICK_DIV-cycle divider. Counts 0..TICK_DIV-1 while enabled and raises
// tick_o during the last count of each period. A synchronous clear holds
// the count at zero so a new period always starts aligned.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear (wins over enable)
//   en_i     : count enable
//   tick_o   : high for the final cycle of each TICK_DIV period
module tick_prescaler
    import absentees_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned      PW   = cnt_width(TICK_DIV);
    localparam logic [PW-1:0]    LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Next count: clear, wrap at LAST, or advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/playback_sequencer.sv
// Playback sequencer: on start, pops durations from the store one at a
// time and drives play_out high for duration*TICK_DIV cycles followed by
// GAP_TICKS*TICK_DIV low cycles. Stops on a zero entry, after MAX_ENTRIES
// entries, or on abort.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of playback_sequencer_if (start/abort/mem_data in,
//              mem_read/play_out/busy/done/entries_played out)
// All bus outputs are registered except mem_read, which is decoded from
// the LOAD state so the store pops on the edge that ends LOAD.
module playback_sequencer
    import absentees_pkg::*;
#(
    parameter int unsigned DATA_W      = DUR_W,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned GAP_TICKS   = 4,
    parameter int unsigned MAX_ENTRIES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    playback_sequencer_if.slave  bus
);

    localparam int unsigned   EW       = $clog2(MAX_ENTRIES + 1);
    localparam int unsigned   GW       = cnt_width(GAP_TICKS);
    localparam logic [EW-1:0] EMAX     = EW'(MAX_ENTRIES);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    play_state_t       state_q, state_d;
    logic [DATA_W-1:0] dur_q, dur_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [EW-1:0]     entries_q, entries_d;
    logic              play_q, play_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick_s;
    logic              presc_run_s;
    logic              stop_load_s;
    logic              accept_s;

    // The shared prescaler only runs in PLAY and GAP; every other state
    // holds it cleared so each PLAY starts on a fresh period.
    assign presc_run_s = (state_q == PLAY) || (state_q == GAP);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (~presc_run_s),
        .en_i   (presc_run_s),
        .tick_o (tick_s)
    );

    assign stop_load_s = (entries_q == EMAX) || (bus.mem_data == '0);
    // A pop is only issued when the entry is actually taken; an abort or
    // reset in the same cycle must leave the store untouched.
    assign accept_s    = (state_q == LOAD) && !stop_load_s && !bus.abort;
    assign bus.mem_read = accept_s & ~rst;

    // FSM next-state and counter updates; abort overrides every state.
    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        entries_d = entries_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d   = LOAD;
                        entries_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (stop_load_s) begin
                        state_d = DONE;
                    end else begin
                        dur_d     = bus.mem_data;
                        entries_d = entries_q + EW'(1);
                        state_d   = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        if (dur_q == DATA_W'(1)) begin
                            if (GAP_TICKS == 0) begin
                                state_d = LOAD;
                            end else begin
                                state_d = GAP;
                                gap_d   = '0;
                            end
                        end else begin
                            dur_d = dur_q - DATA_W'(1);
                        end
                    end else begin
                        dur_d = dur_q;
                    end
                end
                GAP: begin
                    if (tick_s) begin
                        if (gap_q == GAP_LAST) begin
                            state_d = LOAD;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end else begin
                        gap_d = gap_q;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line up
    // exactly with the state they describe.
    always_comb begin
        play_d = (state_d == PLAY);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            gap_q     <= '0;
            entries_q <= '0;
            play_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            entries_q <= entries_d;
            play_q    <= play_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.play_out       = play_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.entries_played = entries_q;

endmodule

// File: tb/tb_playback_sequencer.sv
module tb_playback_sequencer;

    logic clk;
    logic rst;

    playback_sequencer_if #(.DATA_W(12), .MAX_ENTRIES(3)) bus ();
    playback_sequencer_if #(.DATA_W(12), .MAX_ENTRIES(3)) bus2 ();

    playback_sequencer #(
        .DATA_W(12), .TICK_DIV(2), .GAP_TICKS(1), .MAX_ENTRIES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    playback_sequencer #(
        .DATA_W(12), .TICK_DIV(1), .GAP_TICKS(1), .MAX_ENTRIES(3)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Store model: st[] is the sequence of values seen at the top; each pop
    // advances, and the last slot repeats once exhausted.
    logic [11:0] st [0:3];
    int          read_cnt  = 0;
    int          base      = 0;
    int          read_cnt2 = 0;
    int          base2     = 0;
    int          done_cnt  = 0;
    int          high_cnt  = 0;

    always @(posedge clk) begin
        if (bus.mem_read)  read_cnt  <= read_cnt + 1;
        if (bus2.mem_read) read_cnt2 <= read_cnt2 + 1;
        if (bus.done)      done_cnt  <= done_cnt + 1;
        if (bus.play_out)  high_cnt  <= high_cnt + 1;
    end

    always_comb begin
        int idx;
        idx = read_cnt - base;
        if (idx > 3) idx = 3;
        if (idx < 0) idx = 0;
        bus.mem_data  = st[idx];
        bus2.mem_data = (read_cnt2 == base2) ? 12'hFFF : 12'h000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_store(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d);
        st[0] = a; st[1] = b; st[2] = c; st[3] = d;
        base  = read_cnt;
    endtask

    // Count consecutive high cycles of play_out starting now (bounded).
    task automatic measure_high(input int which, output int n);
        n = 0;
        while (((which == 0) ? bus.play_out : bus2.play_out) === 1'b1 && n < 5000) begin
            n++;
            step();
        end
    endtask

    // Starting in a LOAD cycle that accepts: check the pop, the high width
    // and the 2-cycle gap; returns positioned at the following LOAD cycle.
    task automatic play_entry(input string tag, input int exp_high);
        int n;
        chk({tag, "_mem_read"}, int'(bus.mem_read), 1);
        step();
        measure_high(0, n);
        chk({tag, "_high"}, n, exp_high);
        chk({tag, "_gap1_play"}, int'(bus.play_out), 0);
        step();
        chk({tag, "_gap2_play"}, int'(bus.play_out), 0);
        chk({tag, "_gap2_read"}, int'(bus.mem_read), 0);
        step();
    endtask

    initial begin
        int n;
        int d0;
        int h0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;
        st[0] = 12'd0; st[1] = 12'd0; st[2] = 12'd0; st[3] = 12'd0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_play", int'(bus.play_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_read", int'(bus.mem_read), 0);
        chk("rst_entries", int'(bus.entries_played), 0);

        // Single entry 5 then 0.
        load_store(12'd5, 12'd0, 12'd0, 12'd0);
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("s1_load_read", int'(bus.mem_read), 1);
        chk("s1_load_busy", int'(bus.busy), 1);
        chk("s1_load_play", int'(bus.play_out), 0);
        step();
        measure_high(0, n);
        chk("s1_high", n, 10);
        chk("s1_gap1_busy", int'(bus.busy), 1);
        step();
        chk("s1_gap2_play", int'(bus.play_out), 0);
        step();
        chk("s1_zero_read", int'(bus.mem_read), 0);
        chk("s1_zero_done", int'(bus.done), 0);
        step();
        chk("s1_done", int'(bus.done), 1);
        chk("s1_done_busy", int'(bus.busy), 1);
        step();
        chk("s1_idle_done", int'(bus.done), 0);
        chk("s1_idle_busy", int'(bus.busy), 0);
        chk("s1_entries", int'(bus.entries_played), 1);
        chk("s1_reads", read_cnt - base, 1);
        chk("s1_done_pulses", done_cnt - d0, 1);

        // Three entries 3,1,2 then capped while the store keeps returning 2.
        load_store(12'd3, 12'd1, 12'd2, 12'd2);
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        play_entry("m1", 6);
        play_entry("m2", 2);
        play_entry("m3", 4);
        chk("m_cap_read", int'(bus.mem_read), 0);
        step();
        chk("m_done", int'(bus.done), 1);
        step();
        chk("m_busy", int'(bus.busy), 0);
        chk("m_entries", int'(bus.entries_played), 3);
        chk("m_reads", read_cnt - base, 3);
        chk("m_done_pulses", done_cnt - d0, 1);

        // Empty store.
        load_store(12'd0, 12'd0, 12'd0, 12'd0);
        h0 = high_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("e_read", int'(bus.mem_read), 0);
        chk("e_busy", int'(bus.busy), 1);
        step();
        chk("e_done", int'(bus.done), 1);
        step();
        chk("e_busy_end", int'(bus.busy), 0);
        chk("e_entries", int'(bus.entries_played), 0);
        chk("e_reads", read_cnt - base, 0);
        chk("e_high", high_cnt - h0, 0);

        // Abort during the second entry's PLAY.
        load_store(12'd2, 12'd3, 12'd0, 12'd0);
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        play_entry("a1", 4);
        chk("a2_read", int'(bus.mem_read), 1);
        step();
        chk("a2_play", int'(bus.play_out), 1);
        step();
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        chk("a_play", int'(bus.play_out), 0);
        chk("a_busy", int'(bus.busy), 0);
        chk("a_read", int'(bus.mem_read), 0);
        chk("a_entries", int'(bus.entries_played), 2);
        step();
        chk("a_no_done", done_cnt - d0, 0);
        // Start together with abort stays idle.
        bus.start = 1'b1; bus.abort = 1'b1; step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa_busy", int'(bus.busy), 0);
        chk("sa_read", int'(bus.mem_read), 0);
        step();
        chk("sa_busy2", int'(bus.busy), 0);
        chk("sa_entries", int'(bus.entries_played), 2);

        // Start reissued mid-GAP is ignored.
        load_store(12'd2, 12'd1, 12'd0, 12'd0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("b1_read", int'(bus.mem_read), 1);
        step();
        measure_high(0, n);
        chk("b1_high", n, 4);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("b_gap2_play", int'(bus.play_out), 0);
        chk("b_gap2_read", int'(bus.mem_read), 0);
        chk("b_gap2_busy", int'(bus.busy), 1);
        step();
        play_entry("b2", 2);
        chk("b_zero_read", int'(bus.mem_read), 0);
        step();
        chk("b_done", int'(bus.done), 1);
        step();
        chk("b_entries", int'(bus.entries_played), 2);
        chk("b_reads", read_cnt - base, 2);

        // Reset held 3 cycles mid-PLAY.
        load_store(12'd5, 12'd0, 12'd0, 12'd0);
        d0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step(); step();
        chk("r_play_before", int'(bus.play_out), 1);
        rst = 1'b1; repeat (3) step(); rst = 1'b0;
        chk("r_play", int'(bus.play_out), 0);
        chk("r_busy", int'(bus.busy), 0);
        chk("r_done", int'(bus.done), 0);
        chk("r_read", int'(bus.mem_read), 0);
        chk("r_entries", int'(bus.entries_played), 0);
        step();
        chk("r_busy_after", int'(bus.busy), 0);
        chk("r_no_done", done_cnt - d0, 0);

        // Maximum duration 4095 with TICK_DIV=1.
        base2 = read_cnt2;
        bus2.start = 1'b1; step(); bus2.start = 1'b0;
        chk("x_read", int'(bus2.mem_read), 1);
        step();
        measure_high(1, n);
        chk("x_high", n, 4095);
        chk("x_gap_play", int'(bus2.play_out), 0);
        step();
        chk("x_zero_read", int'(bus2.mem_read), 0);
        step();
        chk("x_done", int'(bus2.done), 1);
        step();
        chk("x_busy", int'(bus2.busy), 0);
        chk("x_entries", int'(bus2.entries_played), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
